// File: rtl/burst_mem_responder_if.sv
// Burst memory bus between the cacheline adaptor (master) and the memory responder (slave).
interface burst_mem_responder_if;
  logic        read_i;
  logic        write_i;
  logic [31:0] address_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;
  logic        busy_o;

  modport master (
    output read_i, write_i, address_i, burst_i,
    input  burst_o, resp_o, busy_o
  );

  modport slave (
    input  read_i, write_i, address_i, burst_i,
    output burst_o, resp_o, busy_o
  );
endinterface

// File: rtl/burst_mem_responder.sv
// Line-organised memory responder for the 64-bit, 4-beat burst protocol.
// Define BURST_RESP_STALL_EN to insert one wait-state cycle between beats 1 and 2.
module burst_mem_responder #(
  parameter int unsigned DEPTH_LINES = 16,
  parameter int unsigned LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  burst_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_LINES);
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned BEAT_W = 64;
`ifdef BURST_RESP_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    BURST   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t             state_q;
  logic               is_write_q;
  logic [IDX_W-1:0]   line_q;
  logic [CNT_W-1:0]   lat_cnt_q;
  logic [1:0]         beat_q;
  logic               stall_q;
  logic [LINE_W-1:0]  mem_q [DEPTH_LINES];

  logic [BEAT_W-1:0]  burst_q;
  logic               resp_q;
  logic               busy_q;

  logic               req_c;
  logic [IDX_W-1:0]   addr_idx_c;
  logic [1:0]         beat_nxt_c;
  logic [7:0]         beat_base_c;
  logic [7:0]         beat_nxt_base_c;
  logic [BEAT_W-1:0]  rd_first_c;
  logic [BEAT_W-1:0]  rd_nxt_c;
  logic               unused_addr_bits;

  assign req_c           = bus.read_i | bus.write_i;
  assign addr_idx_c      = bus.address_i[IDX_W+4:5];
  assign beat_nxt_c      = beat_q + 2'd1;
  assign beat_base_c     = {beat_q, 6'd0};
  assign beat_nxt_base_c = {beat_nxt_c, 6'd0};
  assign unused_addr_bits = ^{bus.address_i[31:IDX_W+5], bus.address_i[4:0]};

  // Read data is muted for writes so burst_o only ever carries stored read beats.
  assign rd_first_c = is_write_q ? '0 : mem_q[line_q][BEAT_W-1:0];
  assign rd_nxt_c   = is_write_q ? '0 : mem_q[line_q][beat_nxt_base_c +: BEAT_W];

  // Burst sequencer and storage; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      line_q     <= '0;
      lat_cnt_q  <= '0;
      beat_q     <= '0;
      stall_q    <= 1'b0;
      burst_q    <= '0;
      resp_q     <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < int'(DEPTH_LINES); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          resp_q  <= 1'b0;
          burst_q <= '0;
          stall_q <= 1'b0;
          if (req_c) begin
            is_write_q <= bus.write_i;
            line_q     <= addr_idx_c;
            lat_cnt_q  <= CNT_W'(LATENCY - 1);
            beat_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= WAIT;
          end
        end

        WAIT: begin
          if (!req_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            resp_q  <= 1'b0;
            burst_q <= '0;
          end else if (lat_cnt_q == '0) begin
            state_q <= BURST;
            beat_q  <= '0;
            resp_q  <= 1'b1;
            burst_q <= rd_first_c;
          end else begin
            lat_cnt_q <= lat_cnt_q - CNT_W'(1);
          end
        end

        BURST: begin
          if (!req_c) begin
            // Dropped request: no commit for the beat on screen, straight back to IDLE.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            resp_q  <= 1'b0;
            burst_q <= '0;
            stall_q <= 1'b0;
          end else if (stall_q) begin
            stall_q <= 1'b0;
            beat_q  <= beat_nxt_c;
            resp_q  <= 1'b1;
            burst_q <= rd_nxt_c;
          end else begin
            if (is_write_q) begin
              mem_q[line_q][beat_base_c +: BEAT_W] <= bus.burst_i;
            end
            if (beat_q == 2'd3) begin
              state_q <= RECOVER;
              resp_q  <= 1'b0;
              burst_q <= '0;
            end else if (STALL_EN && (beat_q == 2'd1)) begin
              stall_q <= 1'b1;
              resp_q  <= 1'b0;
              burst_q <= '0;
            end else begin
              beat_q  <= beat_nxt_c;
              resp_q  <= 1'b1;
              burst_q <= rd_nxt_c;
            end
          end
        end

        RECOVER: begin
          resp_q  <= 1'b0;
          burst_q <= '0;
          // Initiator must release the request before another burst is taken.
          if (!req_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          resp_q  <= 1'b0;
          burst_q <= '0;
        end
      endcase
    end
  end

  assign bus.burst_o = burst_q;
  assign bus.resp_o  = resp_q;
  assign bus.busy_o  = busy_q;

endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
- Memory-side responder for the 64-bit, 4-beat burst protocol driven by the cacheline adaptor.
- Backs a small line-organised storage array and answers read/write bursts with a configurable first-beat latency.
- Serves as a synthesizable memory model for block- and system-level simulation of the cache path.
- Also serves as the reference responder against which initiator compliance is checked.

Parameters:
DEPTH_LINES, 16, number of 256-bit lines stored; power of two, >=2
LATENCY, 4, cycles from request acceptance to first beat; >=1

Ports:
clk  input  1  clock
reset_n  input  1  reset, synchronous, active-low
read_i  input  1  read burst request, held by initiator until burst completes
write_i  input  1  write burst request, held by initiator until burst completes
address_i  input  32  line address; bits [4:0] ignored
burst_i  input  64  write data for the current beat
burst_o  output  64  read data for the current beat
resp_o  output  1  beat acknowledge, one cycle per beat
busy_o  output  1  high from request acceptance until return to IDLE

Behaviour:
- Reset (reset_n low at a clk edge):
  - State goes to IDLE; all counters are zeroed.
  - resp_o=0, burst_o=0, busy_o=0.
  - Every storage line is zeroed.
  - Reset mid-burst aborts the burst with no further beats. Write beats already committed are then cleared by the reset.
- Line index = address_i[$clog2(DEPTH_LINES)+4:5]. Upper bits are ignored, so addresses alias (wrap) modulo DEPTH_LINES lines.
- Beat k (k=0..3) maps to line bits [64k+63:64k]. Order is always 0,1,2,3; there is no critical-word-first.
- All outputs are registered.
- States:
  - IDLE: busy_o=0.
    - If read_i or write_i is sampled high, latch op and line index. Write has priority when both are high.
    - Load the latency counter with LATENCY-1, then go to WAIT.
  - WAIT: busy_o=1, resp_o=0.
    - Counter decrements each cycle.
    - At 0, go to BURST with beat=0.
    - For a read, burst_o is preloaded so it is valid in the first resp_o cycle.
  - BURST: resp_o=1 every cycle; the beat counter increments each cycle.
    - Read: burst_o = stored beat[beat] during that resp_o cycle.
    - Write: burst_i is written into beat[beat] of the latched line at the clk edge that ends the resp_o cycle.
    - After beat 3, go to RECOVER.
  - RECOVER: resp_o=0, burst_o=0.
    - Remain until read_i and write_i are both low, then go to IDLE.
    - The deassert is required before a new request is accepted.
- Timing: a request accepted at edge 0 gives resp_o high in cycles LATENCY..LATENCY+3, back-to-back. Total burst occupancy is LATENCY+4 cycles plus the RECOVER cycle(s).
- Request dropped (both low) during WAIT or BURST: abort. resp_o is 0 from the next cycle and the state goes to IDLE. Write beats already committed remain.
- address_i and the op change after acceptance are ignored until the next IDLE acceptance.
- burst_o is 0 whenever resp_o is 0 or the op is a write.

Optional Feature:
- Macro BURST_RESP_STALL_EN.
- Defined: in BURST, after beat 1 the block inserts one stall cycle (resp_o=0, burst_o=0, beat counter held) before beat 2. Burst occupancy becomes LATENCY+5. This exercises initiator wait states.
- Undefined: the four beats are strictly back-to-back.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with read_i=1 -> resp_o=0, busy_o=0, burst_o=0. After release, a read of 0x00000000 returns four beats of 0x0.
- Write then read: write 0x00000040 with beats 0x1111111111111111, 0x2222222222222222, 0x3333333333333333, 0x4444444444444444 -> resp_o high in cycles 4..7 (LATENCY=4). A read of 0x00000040 returns the same four values in order in cycles 4..7.
- Wrap/alias: with DEPTH_LINES=16, read 0x00000240 after the above -> returns 0x1111..,0x2222..,0x3333..,0x4444.. (index 2). A read of 0x00000060 returns zeros.
- Simultaneous request: read_i=1 and write_i=1 at 0x00000020 with beats 0xA..A, 0xB..B, 0xC..C, 0xD..D -> treated as write. A subsequent read of 0x00000020 returns those values.
- Abort and recovery:
  - Drop write_i after beat 1 of a write of 0xFFFF..FF beats to 0x00000080 -> resp_o=0 next cycle, busy_o=0. A read of 0x00000080 returns beats 0,1 = 0xFFFF..FF and beats 2,3 = 0x0.
  - Holding read_i high after a completed burst -> no new resp_o until read_i is low for at least one cycle.
- BURST_RESP_STALL_EN defined, LATENCY=4 -> read resp_o pattern 1,1,0,1,1 in cycles 4..8 with correct beat data.
